// File: rtl/alu_op_sequencer_if.sv
// Request/result handshake bundle for alu_op_sequencer.
// The master issues operations and consumes results; the slave is the sequencer.
interface alu_op_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [3:0] in_op;
  logic       in_use_acc;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_carry;
  logic       out_zero;
  logic       out_div0;

  modport master (
    output in_valid, in_a, in_b, in_op, in_use_acc, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_zero, out_div0
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_use_acc, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_zero, out_div0
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequencer around an external 8-bit combinational ALU: registers operands, waits one
// settle cycle, captures the result with flags, and holds it until the consumer takes it.
module alu_op_sequencer #(
  parameter int         CNT_W      = 16,
  parameter logic [7:0] ACC_INIT   = 8'h00,
  parameter logic [7:0] DIV0_VALUE = 8'hFF
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_op_sequencer_if.slave bus,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_sel,
  output logic             alu_sub,
  input  logic [7:0]       alu_out,
  input  logic             alu_cout,
  output logic [7:0]       acc_value,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_DIV = 4'b0011;

  logic [1:0] state_reg;
  logic       accept;
  logic       div0;
  logic       carry_op;

  assign accept   = bus.in_valid && (state_reg == IDLE);
  assign div0     = (alu_sel == OP_DIV) && (alu_b == 8'h00);
  // Only add and subtract produce a meaningful carry; other ops may leave junk on alu_cout.
  assign carry_op = (alu_sel == OP_ADD) || (alu_sel == OP_SUB);

  assign bus.in_ready = (state_reg == IDLE);
  assign busy         = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      alu_a          <= 8'h00;
      alu_b          <= 8'h00;
      alu_sel        <= 4'h0;
      alu_sub        <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_result <= 8'h00;
      bus.out_carry  <= 1'b0;
      bus.out_zero   <= 1'b0;
      bus.out_div0   <= 1'b0;
      acc_value      <= ACC_INIT;
      op_count       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            alu_a     <= bus.in_use_acc ? acc_value : bus.in_a;
            alu_b     <= bus.in_b;
            alu_sel   <= bus.in_op;
            alu_sub   <= (bus.in_op == OP_SUB);
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          bus.out_valid <= 1'b1;
          state_reg     <= DONE;
          if (div0) begin
            // The ALU's divide-by-zero output is meaningless, so substitute a fixed value
            // and leave the accumulator alone.
            bus.out_result <= DIV0_VALUE;
            bus.out_carry  <= 1'b0;
            bus.out_zero   <= (DIV0_VALUE == 8'h00);
            bus.out_div0   <= 1'b1;
          end else begin
            bus.out_result <= alu_out;
            bus.out_carry  <= carry_op ? alu_cout : 1'b0;
            bus.out_zero   <= (alu_out == 8'h00);
            bus.out_div0   <= 1'b0;
            acc_value      <= alu_out;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            op_count      <= op_count + CNT_W'(1);
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Control and result stage wrapped around the 8-bit combinational ALU. Accepts operations over a valid/ready handshake and registers the operands, select and Sub onto the ALU inputs. Captures ALU_Out/CarryOut and returns the result with flags over a second valid/ready handshake. Also keeps an accumulator that can replace operand A, and counts completed operations.

Parameters:
CNT_W, 16, width of the completed-operation counter
ACC_INIT, 8'h00, accumulator value after reset
DIV0_VALUE, 8'hFF, result returned for divide-by-zero

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request valid
in_ready  output  1  block can accept an operation
in_a  input  8  operand A
in_b  input  8  operand B
in_op  input  4  ALU select code (0000 add, 0001 sub, ..., 1111 equal)
in_use_acc  input  1  use the accumulator as operand A instead of in_a
alu_a  output  8  registered operand to ALU A
alu_b  output  8  registered operand to ALU B
alu_sel  output  4  registered ALU_Sel
alu_sub  output  1  registered Sub; 1 only when op==0001
alu_out  input  8  ALU_Out from the ALU
alu_cout  input  1  CarryOut from the ALU
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_result  output  8  captured result
out_carry  output  1  carry flag
out_zero  output  1  high when out_result==0
out_div0  output  1  divide-by-zero flag
acc_value  output  8  current accumulator
op_count  output  CNT_W  number of completed (handed-off) operations, wraps
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (async, rst_n low):
  - FSM enters IDLE.
  - alu_a, alu_b, alu_sel, alu_sub, out_result, out_carry, out_zero, out_div0, out_valid, op_count reset to 0.
  - acc_value resets to ACC_INIT.
  - in_ready is 1 once reset is released; busy is 0.
  - Reset mid-operation discards the operation in flight; no partial result is presented.
- FSM states: IDLE, EXEC, DONE.
  - IDLE:
    - in_ready=1.
    - On in_valid&&in_ready: alu_a<=(in_use_acc ? acc_value : in_a), alu_b<=in_b, alu_sel<=in_op, alu_sub<=(in_op==4'b0001); go to EXEC.
    - Without in_valid, the alu_* registers hold their last values.
  - EXEC:
    - in_ready=0. The ALU settles during this cycle.
    - At the clock edge, capture the result and go to DONE:
      - out_result<=alu_out.
      - out_carry<=alu_cout when alu_sel is 0000 or 0001, otherwise 0.
      - out_zero<=(captured result==0).
      - out_div0<=0.
      - acc_value<=alu_out.
    - Divide-by-zero: if alu_sel==0011 and alu_b==0, ignore alu_out.
      - out_result<=DIV0_VALUE, out_div0<=1, out_carry<=0, out_zero<=(DIV0_VALUE==0).
      - acc_value is unchanged.
  - DONE:
    - out_valid=1; all out_* are held stable while out_ready is low (indefinite backpressure).
    - On out_ready: out_valid falls next cycle, op_count increments (wraps from all-ones to 0), go to IDLE.
    - in_ready=0 throughout DONE; there is no overlap between hand-off and the next accept.
- Timing:
  - Latency: accept edge N, out_valid high from cycle N+2.
  - Best-case throughput: one operation per 3 cycles.
- Handshake rules:
  - in_* are sampled only on the accept edge and may change freely afterwards.
  - out_valid never drops without out_ready.
- busy = (state != IDLE).
- Width rules:
  - All datapath is 8 bits; the carry comes only from alu_cout.
  - Using the accumulator gives a chain with no intermediate software read.

Test Plan:
- Add: in_a=8'h7F, in_b=8'h01, op=0000, out_ready=1 -> out_valid two cycles after accept; result 8'h80, carry 0, zero 0, acc 8'h80, op_count 1.
- Sub equal: in_a=8'h05, in_b=8'h05, op=0001 -> alu_sub=1; result 8'h00, zero 1, carry 1. Then 8'h03-8'h05 gives result 8'hFE, carry 0.
- Divide-by-zero: in_a=8'h10, in_b=8'h00, op=0011 -> result 8'hFF, div0 1, carry 0, acc unchanged. A following 8'h10/8'h04 gives 8'h04, div0 0.
- Accumulate chain from reset: add 0+3 with in_use_acc=1 (in_a=8'hAA ignored), then add acc+4 with in_use_acc=1 -> results 8'h03 then 8'h07; acc_value 8'h07; op_count 2.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 -> out_* stable, in_ready=0, op_count unchanged. Raise out_ready -> one hand-off, then the pending op is accepted in IDLE.
- Reset mid-EXEC: assert rst_n=0 during EXEC of op 1000 -> all outputs return to reset values immediately, out_valid never asserted, acc=ACC_INIT. Normal operation resumes after release.
